// File: rtl/hawk_axird_arb.sv
// Round-robin AR arbiter for the shared HAWK AXI4 read master.
// Burst owners are kept in an in-order FIFO that steers R beats back to the requester.
module hawk_axird_arb #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 512,
    parameter int MAX_OUT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_arvalid,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_araddr,
    input  logic [NUM_REQ*8-1:0]          req_arlen,
    output logic [NUM_REQ-1:0]            req_arready,
    output logic [NUM_REQ-1:0]            req_rvalid,
    input  logic [NUM_REQ-1:0]            req_rready,
    output logic [DATA_W-1:0]             req_rdata,
    output logic [1:0]                    req_rresp,
    output logic                          req_rlast,
    output logic                          m_arvalid,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [7:0]                    m_arlen,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rlast,
    output logic                          m_rready,
    output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
    output logic                          err_unexp_r
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = $clog2(MAX_OUT+1);

    logic [ADDR_W-1:0] addr_s [NUM_REQ];
    logic [7:0]        len_s  [NUM_REQ];

    logic [IDX_W-1:0]  rr_ptr_r;
    logic [IDX_W-1:0]  winner_s;
    logic [IDX_W-1:0]  rr_next_s;
    logic              found_s;
    logic              full_s;
    logic              grant_s;

    logic              arvalid_r;
    logic [ADDR_W-1:0] araddr_r;
    logic [7:0]        arlen_r;

    logic [IDX_W-1:0]  owner_mem_r [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              err_r;

    logic              fifo_empty_s;
    logic [IDX_W-1:0]  owner_s;
    logic              push_s;
    logic              pop_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_s[g] = req_araddr[g*ADDR_W +: ADDR_W];
        assign len_s[g]  = req_arlen[g*8 +: 8];
    end

    // First asserted requester at or after the RR pointer, wrapping modulo NUM_REQ.
    always_comb begin : winner_search
        logic [IDX_W:0] cand;
        logic           take;
        winner_s = '0;
        found_s  = 1'b0;
        cand     = '0;
        take     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            take     = !found_s && req_arvalid[cand[IDX_W-1:0]];
            winner_s = take ? cand[IDX_W-1:0] : winner_s;
            found_s  = found_s | take;
        end
    end

    // Full check uses registered occupancy, so a same-cycle pop never frees a slot early.
    assign full_s    = (count_r == CNT_W'(MAX_OUT));
    assign grant_s   = rst_ni && !arvalid_r && !full_s && found_s;
    assign rr_next_s = (winner_s == IDX_W'(NUM_REQ-1)) ? '0 : winner_s + IDX_W'(1);

    // One-hot AR accept to the winner in the grant cycle only.
    always_comb begin
        req_arready = '0;
        if (grant_s) begin
            req_arready[winner_s] = 1'b1;
        end else begin
            req_arready = '0;
        end
    end

    assign fifo_empty_s = (count_r == '0);
    assign owner_s      = owner_mem_r[rd_ptr_r];
    assign push_s       = grant_s;
    assign pop_s        = m_rvalid && m_rready && m_rlast;

    // Zero-latency R steering to the FIFO head; nothing is accepted with no burst pending.
    always_comb begin
        req_rvalid = '0;
        m_rready   = 1'b0;
        if (!fifo_empty_s) begin
            req_rvalid[owner_s] = m_rvalid;
            m_rready            = req_rready[owner_s];
        end else begin
            req_rvalid = '0;
            m_rready   = 1'b0;
        end
    end

    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;

    // AR slot: loads on grant, drains on handshake, otherwise holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arvalid_r <= 1'b0;
            araddr_r  <= '0;
            arlen_r   <= 8'd0;
        end else if (grant_s) begin
            arvalid_r <= 1'b1;
            araddr_r  <= addr_s[winner_s];
            arlen_r   <= len_s[winner_s];
        end else if (arvalid_r && m_arready) begin
            arvalid_r <= 1'b0;
        end else begin
            arvalid_r <= arvalid_r;
        end
    end

    // Round-robin pointer advances past each winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_r <= '0;
        end else if (grant_s) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Owner FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                owner_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                owner_mem_r[wr_ptr_r] <= winner_s;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy counter; simultaneous push and pop cancel out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flag for R beats arriving with no burst outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (m_rvalid && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign m_arvalid   = arvalid_r;
    assign m_araddr    = araddr_r;
    assign m_arlen     = arlen_r;
    assign outstanding = count_r;
    assign err_unexp_r = err_r;

endmodule

// File: tb/tb_hawk_axird_arb.sv
// Bench for hawk_axird_arb: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_hawk_axird_arb;

    localparam int N  = 3;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int MO = 4;
    localparam int CW = 3;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      req_arvalid = '0;
    logic [N*AW-1:0]   req_araddr = '0;
    logic [N*8-1:0]    req_arlen = '0;
    logic [N-1:0]      req_arready;
    logic [N-1:0]      req_rvalid;
    logic [N-1:0]      req_rready = '0;
    logic [DW-1:0]     req_rdata;
    logic [1:0]        req_rresp;
    logic              req_rlast;
    logic              m_arvalid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic              m_arready = 1'b0;
    logic              m_rvalid = 1'b0;
    logic [DW-1:0]     m_rdata = '0;
    logic [1:0]        m_rresp = 2'd0;
    logic              m_rlast = 1'b0;
    logic              m_rready;
    logic [CW-1:0]     outstanding;
    logic              err_unexp_r;

    hawk_axird_arb #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_arready(req_arready), .req_rvalid(req_rvalid), .req_rready(req_rready),
        .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rready(m_rready),
        .outstanding(outstanding), .err_unexp_r(err_unexp_r)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] av;
        logic       ar;
        logic       rv;
        logic       rl;
        logic [2:0] e_ard;
        logic [2:0] e_rv;
        logic       e_mrr;
        logic       e_mav;
        int         e_addr;
        logic [2:0] e_out;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] av, input logic ar, input logic rv, input logic rl,
                                input logic [2:0] e_ard, input logic [2:0] e_rv, input logic e_mrr,
                                input logic e_mav, input int e_addr, input logic [2:0] e_out);
        vec_t v;
        v.av = av; v.ar = ar; v.rv = rv; v.rl = rl;
        v.e_ard = e_ard; v.e_rv = e_rv; v.e_mrr = e_mrr;
        v.e_mav = e_mav; v.e_addr = e_addr; v.e_out = e_out;
        return v;
    endfunction

    function automatic logic [AW-1:0] fixed_addr(input int i);
        return 64'h8000_1000 + 64'(i) * 64'h100;
    endfunction

    task automatic set_fixed_reqs();
        for (int i = 0; i < N; i++) begin
            req_araddr[i*AW +: AW] = fixed_addr(i);
            req_arlen[i*8 +: 8]    = 8'(i);
        end
    endtask

    task automatic drive(input logic [2:0] av, input logic ar, input logic rv,
                         input logic rl, input logic [2:0] rr);
        req_arvalid = av; m_arready = ar; m_rvalid = rv; m_rlast = rl; req_rready = rr;
    endtask

    task automatic do_reset();
        drive(3'b000, 1'b0, 1'b0, 1'b0, 3'b000);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    // Reference model state
    int          rr_m;
    bit          slot_v;
    logic [63:0] slot_a;
    logic [7:0]  slot_l;
    int          own_q[$];
    bit          err_m;

    vec_t tv[$];

    initial begin
        // ---- reset values ----
        do_reset();
        #2;
        chk("rst_marvalid", m_arvalid, 0);
        chk("rst_maraddr", m_araddr, 0);
        chk("rst_marlen", m_arlen, 0);
        chk("rst_arready", req_arready, 0);
        chk("rst_rvalid", req_rvalid, 0);
        chk("rst_mrready", m_rready, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err_unexp_r, 0);
        @(posedge clk_i); #1;

        // ---- vector table: contention, backpressure, push+pop, slot hold ----
        tv.push_back(mk(3'b111,1,0,0, 3'b001,3'b000,0, 1, 0,3'd1));
        tv.push_back(mk(3'b111,1,0,0, 3'b000,3'b000,1, 0,-1,3'd1));
        tv.push_back(mk(3'b111,1,0,0, 3'b010,3'b000,1, 1, 1,3'd2));
        tv.push_back(mk(3'b111,1,0,0, 3'b000,3'b000,1, 0,-1,3'd2));
        tv.push_back(mk(3'b111,1,0,0, 3'b100,3'b000,1, 1, 2,3'd3));
        tv.push_back(mk(3'b111,1,0,0, 3'b000,3'b000,1, 0,-1,3'd3));
        tv.push_back(mk(3'b111,1,0,0, 3'b001,3'b000,1, 1, 0,3'd4));
        tv.push_back(mk(3'b111,1,0,0, 3'b000,3'b000,1, 0,-1,3'd4));
        tv.push_back(mk(3'b111,1,0,0, 3'b000,3'b000,1, 0,-1,3'd4));
        tv.push_back(mk(3'b111,1,1,1, 3'b000,3'b001,1, 0,-1,3'd3));
        tv.push_back(mk(3'b111,1,0,0, 3'b010,3'b000,1, 1, 1,3'd4));
        tv.push_back(mk(3'b000,1,1,1, 3'b000,3'b010,1, 0,-1,3'd3));
        tv.push_back(mk(3'b111,1,1,1, 3'b100,3'b100,1, 1, 2,3'd3));
        tv.push_back(mk(3'b000,1,1,1, 3'b000,3'b001,1, 0,-1,3'd2));
        tv.push_back(mk(3'b000,1,1,1, 3'b000,3'b010,1, 0,-1,3'd1));
        tv.push_back(mk(3'b000,1,1,1, 3'b000,3'b100,1, 0,-1,3'd0));
        tv.push_back(mk(3'b001,1,0,0, 3'b001,3'b000,0, 1, 0,3'd1));
        tv.push_back(mk(3'b001,0,0,0, 3'b000,3'b000,1, 1, 0,3'd1));
        tv.push_back(mk(3'b000,1,1,1, 3'b000,3'b001,1, 0,-1,3'd0));

        set_fixed_reqs();
        foreach (tv[i]) begin
            drive(tv[i].av, tv[i].ar, tv[i].rv, tv[i].rl, 3'b111);
            #3;
            chk($sformatf("tbl%0d_arready", i), req_arready, tv[i].e_ard);
            chk($sformatf("tbl%0d_rvalid", i), req_rvalid, tv[i].e_rv);
            chk($sformatf("tbl%0d_mrready", i), m_rready, tv[i].e_mrr);
            @(posedge clk_i); #1;
            chk($sformatf("tbl%0d_marvalid", i), m_arvalid, tv[i].e_mav);
            chk($sformatf("tbl%0d_outstanding", i), outstanding, tv[i].e_out);
            if (tv[i].e_addr >= 0) begin
                chk($sformatf("tbl%0d_araddr", i), m_araddr, fixed_addr(tv[i].e_addr));
                chk($sformatf("tbl%0d_arlen", i), m_arlen, 64'(tv[i].e_addr));
            end
        end

        // ---- burst routing with mid-burst stall ----
        do_reset();
        req_araddr[1*AW +: AW] = 64'h8000_2000; req_arlen[1*8 +: 8] = 8'd3;
        req_araddr[0*AW +: AW] = 64'h8000_1000; req_arlen[0*8 +: 8] = 8'd0;
        drive(3'b010, 1, 0, 0, 3'b111);
        #3 chk("br_grant1", req_arready, 3'b010);
        @(posedge clk_i); #1;
        chk("br_araddr1", m_araddr, 64'h8000_2000);
        chk("br_arlen1", m_arlen, 8'd3);
        drive(3'b001, 1, 0, 0, 3'b111);
        #3 chk("br_slot_busy", req_arready, 3'b000);
        @(posedge clk_i); #1;
        #3 chk("br_grant0", req_arready, 3'b001);
        @(posedge clk_i); #1;
        chk("br_out2", outstanding, 3'd2);
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                drive(3'b000, 1, 1, 0, 3'b101);
                #3;
                chk("br_stall_mrready", m_rready, 0);
                chk("br_stall_rvalid", req_rvalid, 3'b010);
                @(posedge clk_i); #1;
                chk("br_stall_out", outstanding, 3'd2);
            end
            drive(3'b000, 1, 1, logic'(b == 3), 3'b111);
            #3;
            chk($sformatf("br_beat%0d_rvalid", b), req_rvalid, 3'b010);
            chk($sformatf("br_beat%0d_mrready", b), m_rready, 1);
            @(posedge clk_i); #1;
            chk($sformatf("br_beat%0d_out", b), outstanding, (b == 3) ? 3'd1 : 3'd2);
        end
        drive(3'b000, 1, 1, 1, 3'b111);
        #3 chk("br_beat4_rvalid", req_rvalid, 3'b001);
        @(posedge clk_i); #1;
        chk("br_beat4_out", outstanding, 3'd0);

        // ---- unexpected R beat ----
        do_reset();
        drive(3'b000, 1, 1, 1, 3'b111);
        #3;
        chk("ur_mrready", m_rready, 0);
        chk("ur_rvalid", req_rvalid, 0);
        @(posedge clk_i); #1;
        chk("ur_err_set", err_unexp_r, 1);
        drive(3'b000, 1, 0, 0, 3'b111);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            chk("ur_err_sticky", err_unexp_r, 1);
        end

        // ---- asynchronous reset mid-operation ----
        set_fixed_reqs();
        drive(3'b001, 1, 0, 0, 3'b111);
        @(posedge clk_i); #1;
        drive(3'b000, 1, 0, 0, 3'b111);
        @(posedge clk_i); #1;
        drive(3'b010, 0, 0, 0, 3'b111);
        @(posedge clk_i); #1;
        chk("mr_pre_out", outstanding, 3'd2);
        chk("mr_pre_marvalid", m_arvalid, 1);
        drive(3'b111, 0, 0, 0, 3'b111);
        #3 rst_ni = 1'b0;
        #1;
        chk("mr_marvalid", m_arvalid, 0);
        chk("mr_maraddr", m_araddr, 0);
        chk("mr_marlen", m_arlen, 0);
        chk("mr_out", outstanding, 0);
        chk("mr_err", err_unexp_r, 0);
        chk("mr_arready", req_arready, 0);
        chk("mr_rvalid", req_rvalid, 0);
        chk("mr_mrready", m_rready, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        #3 chk("mr_first_grant", req_arready, 3'b001);
        @(posedge clk_i); #1;
        chk("mr_first_addr", m_araddr, fixed_addr(0));

        // ---- randomized traffic against the reference model ----
        do_reset();
        rr_m = 0; slot_v = 0; slot_a = '0; slot_l = '0; own_q.delete(); err_m = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            int          win;
            int          own;
            logic [2:0]  e_ard;
            logic [2:0]  e_rv;
            logic        e_mrr;
            bit          empty;
            req_arvalid = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                req_araddr[i*AW +: AW] = {$urandom, $urandom};
                req_arlen[i*8 +: 8]    = 8'($urandom_range(0, 255));
            end
            m_arready  = ($urandom_range(0, 3) != 0);
            m_rvalid   = (own_q.size() > 0) ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 60) == 0);
            m_rlast    = ($urandom_range(0, 2) == 0);
            req_rready = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
            for (int w = 0; w < DW / 32; w++) m_rdata[w*32 +: 32] = $urandom;
            m_rresp = 2'($urandom_range(0, 3));

            win = -1;
            if (!slot_v && own_q.size() < MO) begin
                for (int k = 0; k < N; k++) begin
                    int i;
                    i = (rr_m + k) % N;
                    if (win < 0 && req_arvalid[i]) win = i;
                end
            end
            e_ard = (win >= 0) ? 3'(1 << win) : 3'b000;
            empty = (own_q.size() == 0);
            own = empty ? 0 : own_q[0];
            e_rv  = (!empty && m_rvalid) ? 3'(1 << own) : 3'b000;
            e_mrr = !empty && req_rready[own];

            #3;
            chk("rnd_arready", req_arready, e_ard);
            chk("rnd_rvalid", req_rvalid, e_rv);
            chk("rnd_mrready", m_rready, e_mrr);
            chk("rnd_rdata", 64'(req_rdata == m_rdata), 64'd1);
            chk("rnd_rresp", req_rresp, m_rresp);
            chk("rnd_rlast", req_rlast, m_rlast);

            @(posedge clk_i);
            if (empty && m_rvalid) err_m = 1;
            if (!empty && m_rvalid && req_rready[own] && m_rlast) void'(own_q.pop_front());
            if (slot_v && m_arready) slot_v = 0;
            if (win >= 0) begin
                slot_v = 1;
                slot_a = req_araddr[win*AW +: AW];
                slot_l = req_arlen[win*8 +: 8];
                own_q.push_back(win);
                rr_m = (win + 1) % N;
            end
            #1;
            chk("rnd_marvalid", m_arvalid, slot_v);
            chk("rnd_outstanding", outstanding, own_q.size());
            chk("rnd_err", err_unexp_r, err_m);
            if (slot_v) begin
                chk("rnd_araddr", m_araddr, slot_a);
                chk("rnd_arlen", m_arlen, slot_l);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hawk_axird_arb.md
Name: hawk_axird_arb

Overview:
- Shares the single HAWK AXI4 read master between NUM_REQ internal requesters:
  - req 0: page-read manager
  - req 1: compression manager
  - req 2: uncompress burst engine
- Arbitrates the AR channel round-robin and records the owner of each accepted burst in an in-order owner FIFO.
- Routes R beats back to the owning requester.
- Replaces ad-hoc state-based muxing of AXI read signals between managers.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_W, 64, AXI address width
- DATA_W, 512, AXI data width
- MAX_OUT, 4, max outstanding AR bursts; power of 2, 2..16

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_arvalid  in  NUM_REQ  per-requester AR valid
- req_araddr  in  NUM_REQ*ADDR_W  per-requester address; slice i = bits [i*ADDR_W +: ADDR_W]
- req_arlen  in  NUM_REQ*8  per-requester burst length (beats-1)
- req_arready  out  NUM_REQ  per-requester AR accept
- req_rvalid  out  NUM_REQ  R valid routed to owner
- req_rready  in  NUM_REQ  per-requester R ready
- req_rdata  out  DATA_W  broadcast read data
- req_rresp  out  2  broadcast response
- req_rlast  out  1  broadcast last
- m_arvalid  out  1  master AR valid (registered)
- m_araddr  out  ADDR_W  master address (registered)
- m_arlen  out  8  master length (registered)
- m_arready  in  1  slave AR ready
- m_rvalid  in  1  slave R valid
- m_rdata  in  DATA_W  slave R data
- m_rresp  in  2  slave R response
- m_rlast  in  1  slave R last
- m_rready  out  1  master R ready
- outstanding  out  clog2(MAX_OUT+1)  owner-FIFO occupancy
- err_unexp_r  out  1  sticky: R beat seen with no outstanding burst

Behaviour:
- Reset values:
  - All outputs 0: m_arvalid, m_araddr, m_arlen, req_arready, req_rvalid, m_rready, outstanding, err_unexp_r.
  - RR pointer = 0; owner FIFO empty.
- AR slot:
  - Single registered slot drives m_araddr, m_arlen and m_arvalid.
  - The slot is free when m_arvalid=0.
  - On m_arvalid && m_arready, m_arvalid clears next cycle.
  - Addr/len are held stable while m_arvalid=1.
  - Maximum throughput is 1 AR per 2 cycles.
- Grant (combinational, cycle t):
  - Condition: slot free && outstanding<MAX_OUT && any req_arvalid.
  - Winner = first asserted requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - req_arready[winner]=1 in cycle t only; all other req_arready bits are 0.
- At the grant edge:
  - Slot loads the winner's addr/len; m_arvalid=1 at t+1.
  - Winner index is pushed into the owner FIFO.
  - RR pointer := (winner+1) mod NUM_REQ.
  - With no grant, the pointer is unchanged.
- Requesters hold addr/len stable while arvalid=1 until their arready; the arbiter does not check this.
- R routing:
  - owner = FIFO head.
  - If FIFO non-empty: req_rvalid[owner]=m_rvalid and m_rready=req_rready[owner]. Purely combinational, zero latency.
  - req_rdata, req_rresp and req_rlast are broadcast from m_*.
  - Pop the FIFO on m_rvalid && m_rready && m_rlast.
- Empty FIFO with m_rvalid=1: m_rready=0, all req_rvalid=0, err_unexp_r:=1. err_unexp_r clears only on reset.
- Simultaneous push and pop in one cycle: outstanding is unchanged and both take effect.
  - A grant is allowed when outstanding==MAX_OUT-1 even if a pop occurs in the same cycle.
  - No grant when outstanding==MAX_OUT, even with a same-cycle pop. Full check is on registered occupancy.
- FIFO pointers wrap modulo MAX_OUT. Occupancy is a separate counter, 0..MAX_OUT.
- rresp!=0 is forwarded unchanged; error handling is owned by the requester.
- Asynchronous reset mid-burst:
  - Drops all state and the slot immediately.
  - Any in-flight slave beats after reset trip err_unexp_r; the system resets the interconnect together with this block.

Test Plan:
- Single requester: req0 arvalid, addr 0x8000_1000, arlen 0, m_arready=1 -> req_arready[0] pulses once; m_arvalid high next cycle with the same addr; one beat with rlast routes req_rvalid[0]; outstanding goes 1 then 0.
- Contention: req0, req1 and req2 all assert continuously, pointer 0 -> grant order 0,1,2,0; each requester's arready is separated by 2 cycles; FIFO order matches the grants.
- Backpressure: MAX_OUT=4, m_arready=1, m_rvalid held 0; 6 requests -> exactly 4 grants; outstanding=4; no further req_arready; first pop re-enables grant.
- Burst routing: req1 arlen=3, req0 arlen=0 accepted in that order; slave returns 4 beats then 1 -> beats 0-3 go to req1 only; 5th beat goes to req0; req_rready[1]=0 mid-burst stalls m_rready.
- Unexpected R: FIFO empty, m_rvalid=1 -> m_rready=0; err_unexp_r=1 and stays set until rst_ni low.
- Reset mid-operation: assert rst_ni while outstanding=2 and m_arvalid=1 -> all outputs 0 immediately; after release, first grant goes to req0.
